subterranean_axi4_lite_cmd_master: RTL

Command-driven AXI4-Lite master that sits directly upstream of the Subterranean AXI4-Lite slave. It turns each command word (operation, partial-byte count, 32-bit data, read-back flag) into one register write to the slave's operation address map. When requested, it then reads the slave's output buffer. It returns exactly one response per command, carrying the read data, an error flag and a timeout flag. It lets a streaming datapath (DMA or message packer) drive the cipher core without a CPU.

---
 rtl/subterranean_axi4_lite_cmd_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/subterranean_axi4_lite_cmd_master.sv
// Command-to-AXI4-Lite bridge for the Subterranean slave: one operation write per command,
// an optional read-back of the output buffer, and exactly one response per command.
module subterranean_axi4_lite_cmd_master #(
  parameter int unsigned READ_DELAY = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_data,
  input  logic        cmd_read,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [7:0]  m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [7:0]  m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_GAP, S_READ, S_RDATA, S_RESP
  } state_t;

  localparam logic        WD_EN    = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LOAD = 8'(READ_DELAY);

  state_t      state;
  logic [15:0] wd_cnt;
  logic [7:0]  gap_cnt;
  logic        aw_done;
  logic        w_done;
  logic        rd_after;

  logic aw_hs, w_hs, wd_expired, partial_op;
  logic unused_resp;

  assign aw_hs       = m_axi_awvalid & m_axi_awready;
  assign w_hs        = m_axi_wvalid & m_axi_wready;
  assign wd_expired  = WD_EN && (wd_cnt == WD_LAST);
  assign partial_op  = (cmd_op == 4'd2) || (cmd_op == 4'd4) || (cmd_op == 4'd6);
  // Only the upper response bit distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign unused_resp = ^{m_axi_bresp[0], m_axi_rresp[0]};

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rd_after      <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      m_axi_wstrb  <= 4'hF;
      m_axi_araddr <= 8'h80;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
            rd_after    <= cmd_read;
            wd_cnt      <= '0;
            if (cmd_op > 4'd8) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else if (cmd_op == 4'd8) begin
              m_axi_arvalid <= 1'b1;
              state         <= S_READ;
            end else begin
              m_axi_awaddr  <= {cmd_op, (partial_op ? cmd_size : 2'b00), 2'b00};
              m_axi_wdata   <= cmd_data;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= S_WRITE;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          // A handshake landing in the expiry cycle still counts as success.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            wd_cnt       <= '0;
            state        <= S_WRESP;
          end else if (wd_expired) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            rsp_err       <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_WRESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_err      <= rsp_err | m_axi_bresp[1];
            if (rd_after) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end else if (wd_expired) begin
            m_axi_bready <= 1'b0;
            rsp_err      <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            m_axi_arvalid <= 1'b1;
            wd_cnt        <= '0;
            state         <= S_READ;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        S_READ: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            wd_cnt        <= '0;
            state         <= S_RDATA;
          end else if (wd_expired) begin
            m_axi_arvalid <= 1'b0;
            rsp_err       <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_RDATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_data     <= m_axi_rdata;
            rsp_err      <= rsp_err | m_axi_rresp[1];
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else if (wd_expired) begin
            m_axi_rready <= 1'b0;
            rsp_err      <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
